// File: rtl/fdtd_ez_update_ctrl.sv
// fdtd_ez_update_ctrl: streams one Ez update sweep over a 1-D FDTD grid.
// Reads Hy/Ez one cell per cycle, feeds the downstream calc stage, realigns
// the calc result to its cell address through a latency-matched valid/address
// pipeline and writes Ez back with a PEC zero at cell 0.
// Optional feature macro: FDTD_EZ_SRC_EN adds a soft source injected at one
// cell (src_en_i / src_addr_i / src_val_i, sampled with start_i).
module fdtd_ez_update_ctrl #(
  parameter int unsigned FDTD_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned CALC_LATENCY    = 5
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              start_i,
  input  logic [ADDR_WIDTH-1:0]             n_cells_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              hy_rd_en_o,
  output logic                              ez_rd_en_o,
  output logic [ADDR_WIDTH-1:0]             rd_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]        hy_rd_data_i,
  input  logic [FDTD_DATA_WIDTH-1:0]        ez_rd_data_i,
  output logic signed [FDTD_DATA_WIDTH-1:0] Hy_old_o,
  output logic signed [FDTD_DATA_WIDTH-1:0] Ez_old_o,
  output logic                              clken_o,
  input  logic signed [FDTD_DATA_WIDTH-1:0] Ez_n_i,
  output logic                              ez_wr_en_o,
  output logic [ADDR_WIDTH-1:0]             ez_wr_addr_o,
  output logic [FDTD_DATA_WIDTH-1:0]        ez_wr_data_o
`ifdef FDTD_EZ_SRC_EN
  ,
  input  logic                              src_en_i,
  input  logic [ADDR_WIDTH-1:0]             src_addr_i,
  input  logic signed [FDTD_DATA_WIDTH-1:0] src_val_i
`endif
);

  // Read issue + read latency + operand register + calc latency.
  localparam int unsigned LAT = CALC_LATENCY + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   k_d;
  logic [ADDR_WIDTH-1:0]   n_q, n_d;
  logic                    rd_en_d;
  logic                    busy_d, done_d, clken_d;
  logic                    accept;

  logic                    cap_q;
  logic [LAT-1:0]          pv_q;
  logic [ADDR_WIDTH-1:0]   pa_q [LAT];
  logic                    pipe_empty;
  logic signed [FDTD_DATA_WIDTH-1:0] wr_data_c;

`ifdef FDTD_EZ_SRC_EN
  logic                              src_en_q;
  logic [ADDR_WIDTH-1:0]             src_addr_q;
  logic signed [FDTD_DATA_WIDTH-1:0] src_val_q;
`endif

  // Only the output stage may still be valid when the sweep is allowed to finish.
  assign pipe_empty = ~|pv_q[LAT-2:0];

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    k_d     = rd_addr_o;
    n_d     = n_q;
    rd_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    clken_d = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          busy_d = 1'b1;
          if (n_cells_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_STREAM;
            n_d     = n_cells_i;
            k_d     = '0;
            rd_en_d = 1'b1;
            clken_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        busy_d  = 1'b1;
        clken_d = 1'b1;
        if (rd_addr_o == n_q - ADDR_WIDTH'(1)) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d     = rd_addr_o + ADDR_WIDTH'(1);
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
          clken_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and registered control outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      rd_addr_o  <= '0;
      n_q        <= '0;
      hy_rd_en_o <= 1'b0;
      ez_rd_en_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      clken_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_o  <= k_d;
      n_q        <= n_d;
      hy_rd_en_o <= rd_en_d;
      ez_rd_en_o <= rd_en_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      clken_o    <= clken_d;
    end
  end

`ifdef FDTD_EZ_SRC_EN
  // Source configuration captured when a sweep is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src_en_q   <= 1'b0;
      src_addr_q <= '0;
      src_val_q  <= '0;
    end else if (accept) begin
      src_en_q   <= src_en_i;
      src_addr_q <= src_addr_i;
      src_val_q  <= src_val_i;
    end
  end
`endif

  // Operand capture and the (valid, address) alignment pipeline.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_q    <= 1'b0;
      Hy_old_o <= '0;
      Ez_old_o <= '0;
      pv_q     <= '0;
      for (int i = 0; i < int'(LAT); i++) pa_q[i] <= '0;
    end else begin
      cap_q <= hy_rd_en_o;
      if (cap_q) begin
        Hy_old_o <= $signed(hy_rd_data_i);
        Ez_old_o <= $signed(ez_rd_data_i);
      end
      pv_q    <= {pv_q[LAT-2:0], hy_rd_en_o};
      pa_q[0] <= rd_addr_o;
      for (int i = 1; i < int'(LAT); i++) pa_q[i] <= pa_q[i-1];
    end
  end

  assign ez_wr_en_o   = pv_q[LAT-1];
  assign ez_wr_addr_o = pa_q[LAT-1];

  // Write data: calc result passes straight through, with the PEC zero at cell 0.
  always_comb begin
    wr_data_c = Ez_n_i;
`ifdef FDTD_EZ_SRC_EN
    if (src_en_q && (ez_wr_addr_o == src_addr_q)) wr_data_c = Ez_n_i + src_val_q;
`endif
    if (!ez_wr_en_o || (ez_wr_addr_o == '0)) wr_data_c = '0;
  end

  assign ez_wr_data_o = wr_data_c;

endmodule

// File: tb/tb_fdtd_ez_update_ctrl.sv
// Bench for fdtd_ez_update_ctrl: memory and calc-stage models around the DUT,
// a cycle-indexed sweep model checked every cycle, plus literal expectations.
module tb_fdtd_ez_update_ctrl;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned CL  = 5;
  localparam int          LAT = int'(CL) + 2;
  localparam logic signed [DW-1:0] CEZHY = 3;
  localparam logic signed [DW-1:0] CEZE  = 2;

  logic                 CLK, RST_N;
  logic                 start_i;
  logic [AW-1:0]        n_cells_i;
  logic                 busy_o, done_o, hy_rd_en_o, ez_rd_en_o, clken_o;
  logic [AW-1:0]        rd_addr_o, ez_wr_addr_o;
  logic [DW-1:0]        hy_rd_data_i, ez_rd_data_i, ez_wr_data_o;
  logic signed [DW-1:0] Hy_old_o, Ez_old_o, Ez_n_i;
  logic                 ez_wr_en_o;
`ifdef FDTD_EZ_SRC_EN
  logic                 src_en_i;
  logic [AW-1:0]        src_addr_i;
  logic signed [DW-1:0] src_val_i;
`endif

  fdtd_ez_update_ctrl #(.FDTD_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CALC_LATENCY(CL)) dut (
    .CLK(CLK), .RST_N(RST_N), .start_i(start_i), .n_cells_i(n_cells_i),
    .busy_o(busy_o), .done_o(done_o), .hy_rd_en_o(hy_rd_en_o), .ez_rd_en_o(ez_rd_en_o),
    .rd_addr_o(rd_addr_o), .hy_rd_data_i(hy_rd_data_i), .ez_rd_data_i(ez_rd_data_i),
    .Hy_old_o(Hy_old_o), .Ez_old_o(Ez_old_o), .clken_o(clken_o), .Ez_n_i(Ez_n_i),
    .ez_wr_en_o(ez_wr_en_o), .ez_wr_addr_o(ez_wr_addr_o), .ez_wr_data_o(ez_wr_data_o)
`ifdef FDTD_EZ_SRC_EN
    , .src_en_i(src_en_i), .src_addr_i(src_addr_i), .src_val_i(src_val_i)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Field memories (read-only sources) with 1-cycle read latency.
  logic signed [DW-1:0] hy_mem [64];
  logic signed [DW-1:0] ez_mem [64];
  always @(posedge CLK) begin
    if (hy_rd_en_o) hy_rd_data_i <= hy_mem[rd_addr_o[5:0]];
    if (ez_rd_en_o) ez_rd_data_i <= ez_mem[rd_addr_o[5:0]];
  end

  // Calc stage: 5-cycle delay of (Hy - Hy_prev)*cezhy + Ez*ceze.
  logic signed [DW-1:0] cp [5];
  logic signed [DW-1:0] hy_prev;
  always @(posedge CLK) begin
    cp[0] <= (Hy_old_o - hy_prev) * CEZHY + Ez_old_o * CEZE;
    for (int i = 1; i < 5; i++) cp[i] <= cp[i-1];
    hy_prev <= Hy_old_o;
  end
  assign Ez_n_i = cp[4];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
    end
  endtask

  // Closed-form Ez update for cell k from the field memories.
  function automatic logic signed [DW-1:0] exp_ez(input int k);
    if (k == 0) return '0;
    return (hy_mem[k] - hy_mem[k-1]) * CEZHY + ez_mem[k] * CEZE;
  endfunction

  // Sweep model state.
  bit  active = 0;
  int  t0 = 0;
  int  mn = 0;
  int  accepts = 0;
  int  wr_cnt = 0;
  int  done_rel = -1;
  logic signed [DW-1:0] wr_log [64];
`ifdef FDTD_EZ_SRC_EN
  bit m_src_en = 0;
  int m_src_addr = 0;
  logic signed [DW-1:0] m_src_val = 0;
`endif

  // Per-cycle comparison against the sweep model.
  always @(negedge CLK) begin
    automatic int d = cyc - t0;
    automatic logic [5:0] e_ctl = '0;
    automatic bit e_rd = 0, e_wr = 0, e_busy = 0, e_done = 0, e_clk = 0;
    automatic int end_d;
    automatic logic signed [DW-1:0] e_data;
    if (!RST_N) begin
      active = 0;
      chk("reset_ctl", DW'({busy_o, done_o, clken_o, hy_rd_en_o, ez_rd_en_o, ez_wr_en_o}), '0);
      chk("reset_ops", DW'(Hy_old_o | Ez_old_o), '0);
      chk("reset_addr", DW'({rd_addr_o, ez_wr_addr_o}), '0);
      chk("reset_wdata", ez_wr_data_o, '0);
    end else begin
      if (active) begin
        if (mn == 0) begin
          e_busy = (d == 1);
          e_done = (d == 1);
        end else begin
          e_rd   = (d >= 1) && (d <= mn);
          e_clk  = (d >= 1) && (d <= mn + LAT);
          e_busy = e_clk;
          e_wr   = (d >= LAT + 1) && (d <= mn + LAT);
          e_done = (d == mn + LAT + 1);
          if (d >= 3 && d <= mn + 2) begin
            chk("hy_old", Hy_old_o, hy_mem[d-3]);
            chk("ez_old", Ez_old_o, ez_mem[d-3]);
          end
        end
      end
      e_ctl = {e_busy, e_done, e_clk, e_rd, e_rd, e_wr};
      chk("ctl{busy,done,clken,hyrd,ezrd,wr}",
          DW'({busy_o, done_o, clken_o, hy_rd_en_o, ez_rd_en_o, ez_wr_en_o}), DW'(e_ctl));
      if (e_rd) chk("rd_addr", DW'(rd_addr_o), DW'(d - 1));
      if (e_wr) begin
        e_data = exp_ez(d - 1 - LAT);
`ifdef FDTD_EZ_SRC_EN
        if (m_src_en && (d - 1 - LAT) == m_src_addr && m_src_addr != 0) e_data = e_data + m_src_val;
`endif
        chk("wr_addr", DW'(ez_wr_addr_o), DW'(d - 1 - LAT));
        chk("wr_data", ez_wr_data_o, e_data);
      end
      if (ez_wr_en_o) begin
        wr_cnt++;
        wr_log[ez_wr_addr_o[5:0]] = ez_wr_data_o;
      end
      if (done_o) done_rel = d;
      end_d = (mn == 0) ? 1 : mn + LAT + 1;
      if (start_i && (!active || d >= end_d + 1)) begin
        active = 1;
        t0 = cyc;
        mn = int'(n_cells_i);
        accepts++;
`ifdef FDTD_EZ_SRC_EN
        m_src_en = src_en_i;
        m_src_addr = int'(src_addr_i);
        m_src_val = src_val_i;
`endif
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge CLK); #2;
    start_i   = 1'b1;
    n_cells_i = AW'(n);
    @(posedge CLK); #2;
    start_i   = 1'b0;
    n_cells_i = AW'($urandom_range(0, 1023));
  endtask

  task automatic clr_log();
    wr_cnt = 0;
    done_rel = -1;
    for (int i = 0; i < 64; i++) wr_log[i] = 'x;
  endtask

  initial begin
    int base;
    bit got;
    RST_N = 1'b0;
    start_i = 1'b0;
    n_cells_i = '0;
`ifdef FDTD_EZ_SRC_EN
    src_en_i = 1'b0;
    src_addr_i = '0;
    src_val_i = '0;
`endif
    for (int i = 0; i < 64; i++) begin
      hy_mem[i] = (i < 4) ? '0 : DW'(i * 7 - 3);
      ez_mem[i] = (i < 4) ? '0 : DW'(5 - i);
    end
    hy_mem[1] = 10;
    hy_mem[2] = 30;
    hy_mem[3] = 60;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // N = 4 basic sweep with hand-computed results.
    clr_log();
    do_start(4);
    repeat (16) @(posedge CLK);
    chk("n4_ez0_pec", wr_log[0], 0);
    chk("n4_ez1", wr_log[1], 30);
    chk("n4_ez2", wr_log[2], 60);
    chk("n4_ez3", wr_log[3], 90);
    chk("n4_done_cycle", DW'(done_rel), 12);
    chk("n4_write_count", DW'(wr_cnt), 4);

    // N = 0: no accesses, done at cycle 1.
    clr_log();
    do_start(0);
    repeat (4) @(posedge CLK);
    chk("n0_done_cycle", DW'(done_rel), 1);
    chk("n0_write_count", DW'(wr_cnt), 0);

    // N = 8 with a second start pulse at cycle 5 that must be ignored.
    clr_log();
    do_start(8);
    repeat (4) @(posedge CLK);
    #2 start_i = 1'b1;
    n_cells_i = AW'(3);
    @(posedge CLK); #2 start_i = 1'b0;
    repeat (20) @(posedge CLK);
    chk("n8_write_count", DW'(wr_cnt), 8);
    chk("n8_done_cycle", DW'(done_rel), 16);

    // N = 16 aborted by reset at cycle 6, then a fresh N = 2 sweep.
    do_start(16);
    repeat (5) @(posedge CLK);
    #2 RST_N = 1'b0;
    clr_log();
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (30) @(posedge CLK);
    chk("abort_write_count", DW'(wr_cnt), 0);
    chk("abort_no_done", DW'(done_rel), DW'(-1));
    clr_log();
    do_start(2);
    repeat (14) @(posedge CLK);
    chk("n2_write_count", DW'(wr_cnt), 2);
    chk("n2_done_cycle", DW'(done_rel), 10);

    // Back-to-back N = 3 sweeps with start held high.
    clr_log();
    base = accepts;
    got = 0;
    @(posedge CLK); #2;
    start_i = 1'b1;
    n_cells_i = AW'(3);
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge CLK); #2;
      if (accepts >= base + 2) got = 1;
    end
    start_i = 1'b0;
    chk("b2b_second_accept", DW'(got), 1);
    repeat (16) @(posedge CLK);
    chk("b2b_write_count", DW'(wr_cnt), 6);

`ifdef FDTD_EZ_SRC_EN
    // Soft source at cell 2.
    clr_log();
    src_en_i = 1'b1;
    src_addr_i = AW'(2);
    src_val_i = 100;
    do_start(4);
    src_en_i = 1'b0;
    repeat (16) @(posedge CLK);
    chk("src_ez2", wr_log[2], 160);
    chk("src_ez3", wr_log[3], 90);
    chk("src_ez0_pec", wr_log[0], 0);
`endif

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdtd_ez_update_ctrl.md
# fdtd_ez_update_ctrl

Sequencer that streams one Ez update sweep over a 1-D FDTD grid through the Ez calculation stage that sits directly downstream of it. It reads Hy and Ez from field memories one cell per cycle, presents them with the stage clock-enable, and aligns the stage output to its cell address with a latency-matched valid pipeline. It writes Ez back with a PEC boundary at cell 0 and reports completion to the time-step scheduler.

## Interface
Parameters:
- FDTD_DATA_WIDTH, 32, field/coefficient word width
- ADDR_WIDTH, 10, cell address width
- CALC_LATENCY, 5, cycles from Hy_old_o/Ez_old_o valid to matching Ez_n_i at the calc stage

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous, active-low reset
- start_i  in  1  sweep request, sampled only in IDLE
- n_cells_i  in  ADDR_WIDTH  number of cells N, sampled with start_i
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- hy_rd_en_o, ez_rd_en_o  out  1  memory read strobes
- rd_addr_o  out  ADDR_WIDTH  shared read address for Hy and Ez memories
- hy_rd_data_i, ez_rd_data_i  in  FDTD_DATA_WIDTH  read data, 1-cycle read latency
- Hy_old_o, Ez_old_o  out  FDTD_DATA_WIDTH signed  registered operands to calc stage
- clken_o  out  1  calc stage clock-enable
- Ez_n_i  in  FDTD_DATA_WIDTH signed  calc stage result
- ez_wr_en_o  out  1  Ez write strobe
- ez_wr_addr_o  out  ADDR_WIDTH  Ez write address
- ez_wr_data_o  out  FDTD_DATA_WIDTH  Ez write data

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE → STREAM on start_i when n_cells_i ≥ 1. Latch N and clear the read counter k.
- IDLE → DONE on start_i when n_cells_i = 0. No memory accesses occur.
- STREAM: assert hy_rd_en_o and ez_rd_en_o with rd_addr_o = k. Increment k every cycle with no gaps and no backpressure. After issuing k = N−1, go to DRAIN.
- Read data is registered into Hy_old_o/Ez_old_o one cycle after it returns. Both hold their value when no data is returning.
- The valid/address pipeline has depth LAT = CALC_LATENCY + 2 and carries (valid, k). Its output drives ez_wr_en_o and ez_wr_addr_o.
- ez_wr_data_o = Ez_n_i, except a write to address 0 carries 0 (PEC: the difference at cell 0 uses a stale Hy).
- DRAIN → DONE when the valid pipeline is empty. DONE lasts one cycle: done_o = 1, then return to IDLE.
- clken_o = 1 in STREAM and DRAIN, 0 otherwise.
- start_i while busy is ignored. n_cells_i is ignored outside acceptance.
- The Ez memory is dual-port. Write k always trails read k, so there is no read-after-write hazard within a sweep.

## Timing
- Start accepted at cycle 0. Read k issued at cycle 1+k. Hy_old_o/Ez_old_o for cell k are valid at cycle 3+k.
- Write for cell k occurs at cycle 1+k+LAT. The last write is at cycle N+LAT. done_o is at cycle N+LAT+1, and busy_o drops in the same cycle.
- N = 0: done_o at cycle 1. busy_o is high only during cycle 1.
- Reset values: all outputs 0, FSM IDLE, k = 0, valid pipeline cleared.
- Reset asserted mid-sweep aborts immediately. No further writes and no done_o. The next start_i begins a fresh sweep.

## Configuration
- FDTD_EZ_SRC_EN defined: adds ports src_en_i (1), src_addr_i (ADDR_WIDTH) and src_val_i (FDTD_DATA_WIDTH signed), all sampled at start_i.
  - When src_en_i is latched high, the write to src_addr_i carries Ez_n_i + src_val_i, using wrap-around two's-complement arithmetic.
  - If src_addr_i = 0, the PEC zero takes precedence.
- FDTD_EZ_SRC_EN undefined: these ports do not exist and write data is unmodified.

## Test plan
- CALC_LATENCY = 5, N = 4, start at cycle 0 → reads at cycles 1–4 for addr 0–3. Writes at cycles 8–11 for addr 0–3, with data at addr 0 = 0. done_o at cycle 12. clken_o high during cycles 1–11.
- Model the calc stage as a 5-cycle delay of (Hy−Hy_prev)·cezhy + Ez·ceze, with Hy memory = {0, 10, 30, 60} and Ez memory = 0 → written Ez[1..3] match the model and Ez[0] = 0.
- start_i with n_cells_i = 0 → no rd/wr strobes, done_o at cycle 1. Pulse start_i again at cycle 5 during a running N = 8 sweep → second pulse ignored, exactly 8 writes.
- RST_N asserted at cycle 6 of an N = 16 sweep → all outputs 0 next cycle, no further writes, no done_o. A new N = 2 sweep then completes normally.
- With FDTD_EZ_SRC_EN, src_en_i = 1, src_addr_i = 2, src_val_i = 100, Ez_n_i = −40 for cell 2 → ez_wr_data_o = 60 at addr 2. Other addresses are unaltered.
- Back-to-back sweeps with start_i held high → second sweep is accepted the cycle after DONE, with no overlap of write strobes between sweeps.
